// File: rtl/mips_pkg.sv
// Shared J-type encoding constants for the jump encoder and its users.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
//
// Contents: default J/JAL opcodes, error-bit positions, J-type field
// positions, the stage-1 request struct and the PC+4 helper.
package mips_pkg;

   localparam logic [5:0] OPC_J_DEF   = 6'b000010;
   localparam logic [5:0] OPC_JAL_DEF = 6'b000011;

   // Bit positions within the 2-bit error vector.
   localparam int ERR_MISALIGN = 0;
   localparam int ERR_REGION   = 1;

   // J-type instruction fields.
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int IDX_MSB = 25;
   localparam int IDX_LSB = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        link;
   } jreq_t;

   // Address of the delay-slot instruction; wraps modulo 2^32.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/jump_encoder_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Latency: count reflects an increment one edge after inc is sampled.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, reset (async active-high), inc, count[W-1:0].
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/jump_encoder.sv
// Builds J/JAL instruction words from (pc, target), flagging misaligned or out-of-region targets.
// Latency: 2 cycles from input accept to out_valid; 1 result per cycle sustained.
// Backpressure: full valid/ready; holds 2 requests, output held stable while out_ready is low.
//
// Ports: clk, reset (async active-high);
//        in_valid/in_ready/in_pc/in_target/in_link  - request channel;
//        out_valid/out_ready/out_instr/out_err      - result channel;
//        enc_count/err_count                        - saturating delivery statistics.
module jump_encoder
   import mips_pkg::*;
#(
   parameter logic [5:0] OPC_J   = OPC_J_DEF,
   parameter logic [5:0] OPC_JAL = OPC_JAL_DEF,
   parameter int         CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_target,
   input  logic             in_link,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [1:0]       out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   logic        s1_valid;
   jreq_t       s1_q;
   logic        out_adv;
   logic        s1_adv;
   logic        in_fire;
   logic [31:0] pc4;
   logic [1:0]  err_d;
   logic [31:0] instr_d;
   logic        out_fire;

   // in_ready depends only on state and out_ready, never on in_valid.
   assign out_adv  = !out_valid || out_ready;
   assign s1_adv   = s1_valid && out_adv;
   assign in_ready = !s1_valid || out_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Stage 1: capture the request. The payload register only loads on an
   // accepted transfer so idle-cycle X on the inputs never enters the pipe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
      end else if (in_fire) begin
         s1_q <= '{pc: in_pc, target: in_target, link: in_link};
      end
   end

   // Encode from stage-1 contents. The region check compares against the
   // top nibble of pc+4 because that is what the jump datapath splices in.
   always_comb begin
      pc4                  = pc_plus4(s1_q.pc);
      err_d                = 2'b00;
      err_d[ERR_MISALIGN]  = (s1_q.target[1:0] != 2'b00);
      err_d[ERR_REGION]    = (s1_q.target[31:28] != pc4[31:28]);
      instr_d              = 32'h0;
      if (err_d == 2'b00) begin
         instr_d[OPC_MSB:OPC_LSB] = s1_q.link ? OPC_JAL : OPC_J;
         instr_d[IDX_MSB:IDX_LSB] = s1_q.target[27:2];
      end
   end

   // Stage 2: output register. When the output advances with stage 1 empty
   // the valid drops but the payload is left untouched (not observable).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_instr <= 32'h0;
         out_err   <= 2'b00;
      end else if (out_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_instr <= instr_d;
            out_err   <= err_d;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_enc_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_fire && (out_err == 2'b00)),
      .count (enc_count)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_fire && (out_err != 2'b00)),
      .count (err_count)
   );

endmodule

// File: tb/tb_jump_encoder.sv
// Directed and randomized bench for jump_encoder with immediate-assertion checks.
// Latency: expects out_valid two edges after accept, one result per cycle.
// Backpressure: drives out_ready low/random and checks hold and ordering.
module tb_jump_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_target;
   logic        in_link;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [1:0]  out_err;
   logic [15:0] enc_count;
   logic [15:0] err_count;

   // Narrow-counter instance used only to reach saturation quickly.
   logic        s_valid;
   logic        s_ready;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [31:0] s_instr;
   logic [1:0]  s_err;
   logic [3:0]  s_enc;
   logic [3:0]  s_errc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jump_encoder u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_target (in_target),
      .in_link   (in_link),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   jump_encoder #(.CNT_W(4)) u_sat (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s_valid),
      .in_ready  (s_ready),
      .in_pc     (in_pc),
      .in_target (in_target),
      .in_link   (in_link),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_instr (s_instr),
      .out_err   (s_err),
      .enc_count (s_enc),
      .err_count (s_errc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {err[1:0], instr[31:0]} written from the decode relation.
   function automatic logic [33:0] model(input logic [31:0] pc, input logic [31:0] tgt,
                                         input logic lnk);
      logic [31:0] nxt;
      logic [1:0]  e;
      logic [31:0] w;
      nxt  = pc + 32'd4;
      e[0] = (tgt % 4) != 0;
      e[1] = (tgt >> 28) != (nxt >> 28);
      w    = 32'h0;
      if (e == 2'b00) w = ((lnk ? 32'd3 : 32'd2) << 26) | ((tgt >> 2) & 32'h03FF_FFFF);
      return {e, w};
   endfunction

   // One isolated request with out_ready=1; returns at the negedge where the
   // result is visible (it transfers on the following edge).
   task automatic single(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic lnk, input logic [31:0] exp_instr, input logic [1:0] exp_err);
      @(negedge clk);
      in_valid = 1'b1; in_pc = pc; in_target = tgt; in_link = lnk; out_ready = 1'b1;
      #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_pc = 'x; in_target = 'x; in_link = 1'bx;
      check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_instr"}, out_instr, exp_instr);
      check({tag, "_err"}, 32'(out_err), 32'(exp_err));
   endtask

   logic [33:0] q[$];
   logic [33:0] e;
   logic [31:0] r_pc, r_tgt;
   logic        r_lnk;
   int sent, recv, cyc, good, bad;
   logic [15:0] enc0, err0;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_target = '0; in_link = 1'b0;
      out_ready = 1'b0; s_valid = 1'b0; s_out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_instr", out_instr, 32'h0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_enc", 32'(enc_count), 32'd0);
      check("rst_errc", 32'(err_count), 32'd0);
      @(negedge clk); reset = 1'b0;

      // Directed encodes.
      single("basic", 32'h0040_0000, 32'h0040_0020, 1'b0, 32'h0810_0008, 2'b00);
      @(negedge clk);
      check("basic_enc", 32'(enc_count), 32'd1);
      check("basic_out_drained", 32'(out_valid), 32'd0);
      single("jal", 32'h0040_0000, 32'h0040_0020, 1'b1, 32'h0C10_0008, 2'b00);
      single("misalign", 32'h0040_0000, 32'h0040_0022, 1'b0, 32'h0, 2'b01);
      @(negedge clk);
      check("misalign_errc", 32'(err_count), 32'd1);
      check("misalign_enc", 32'(enc_count), 32'd2);
      single("region", 32'h0FFF_FFFC, 32'h0FFF_FF00, 1'b0, 32'h0, 2'b10);
      single("wrap", 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 32'h0800_0004, 2'b00);
      single("both", 32'h0040_0000, 32'h1000_0002, 1'b1, 32'h0, 2'b11);
      @(negedge clk);
      check("dir_enc", 32'(enc_count), 32'd3);
      check("dir_errc", 32'(err_count), 32'd3);

      // Backpressure: three back-to-back requests with the consumer stalled.
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h0040_0000; in_target = 32'h0040_0020; in_link = 1'b0;
      #1 check("bp_a_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_link = 1'b1;
      #1 check("bp_b_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_link = 1'b0; in_target = 32'h0040_0024;
      #1 check("bp_c_blocked", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_instr", out_instr, 32'h0810_0008);
      @(negedge clk);
      check("bp_still_blocked", 32'(in_ready), 32'd0);
      check("bp_stable_instr", out_instr, 32'h0810_0008);
      check("bp_stable_err", 32'(out_err), 32'd0);
      out_ready = 1'b1;
      #1 check("bp_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_pc = 'x; in_target = 'x; in_link = 1'bx;
      check("bp_order_b", out_instr, 32'h0C10_0008);
      @(negedge clk);
      check("bp_order_c_valid", 32'(out_valid), 32'd1);
      check("bp_order_c", out_instr, 32'h0810_0009);
      @(negedge clk);
      check("bp_drained", 32'(out_valid), 32'd0);
      check("bp_enc", 32'(enc_count), 32'd6);

      // Randomized stream against the reference model.
      enc0 = enc_count; err0 = err_count;
      sent = 0; recv = 0; cyc = 0; good = 0; bad = 0;
      while ((sent < 100 || recv < 100) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (sent < 100 && $urandom_range(0, 3) != 0) begin
            r_pc  = $urandom;
            r_tgt = {r_pc[31:28] + 4'(r_pc[27:2] == 26'h3FF_FFFF), 28'($urandom)};
            if ($urandom_range(0, 7) == 0) r_tgt[31:28] = 4'($urandom);
            if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
            r_lnk = 1'($urandom);
            in_valid = 1'b1; in_pc = r_pc; in_target = r_tgt; in_link = r_lnk;
         end else begin
            in_valid = 1'b0; in_pc = 'x; in_target = 'x; in_link = 1'bx;
         end
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("stream_unexpected", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("stream_instr", out_instr, e[31:0]);
               check("stream_err", 32'(out_err), 32'(e[33:32]));
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            e = model(in_pc, in_target, in_link);
            q.push_back(e);
            if (e[33:32] == 2'b00) good++; else bad++;
            sent++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("stream_recv", 32'(recv), 32'd100);
      check("stream_total", 32'(enc_count - enc0) + 32'(err_count - err0), 32'd100);
      check("stream_enc_delta", 32'(enc_count - enc0), 32'(good));

      // Reset with two requests in flight.
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h0040_0000; in_target = 32'h0040_0020; in_link = 1'b0;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_enc", 32'(enc_count), 32'd0);
      check("mid_rst_errc", 32'(err_count), 32'd0);
      @(negedge clk);
      reset = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_stale", 32'(out_valid), 32'd0);
      end

      // Saturation on the 4-bit instance: 20 good results -> sticks at 15.
      in_pc = 32'h0040_0000; in_target = 32'h0040_0020; in_link = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 20; i++) @(negedge clk);
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      check("sat_enc", 32'(s_enc), 32'd15);
      check("sat_errc", 32'(s_errc), 32'd0);
      in_target = 32'h0040_0021;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("sat_err_one", 32'(s_errc), 32'd1);
      check("sat_enc_hold", 32'(s_enc), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jump_encoder.md
Name: jump_encoder

Overview:
- Inverse of the datapath jump-target formation. Takes a jump instruction address (PC) and a desired absolute target, and produces the 32-bit J or JAL instruction word. Decoding the result gives {(PC+4)[31:28], instr[25:0], 2'b00} == target.
- Used by the instruction-memory loader and by self-modifying test harnesses.
- Validates alignment and 256 MB region. Two-stage valid/ready pipeline with full backpressure, plus saturating statistics counters.

Parameters:
- OPC_J, 6'b000010, opcode emitted when in_link=0.
- OPC_JAL, 6'b000011, opcode emitted when in_link=1.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_pc  input  32  address of the jump instruction.
- in_target  input  32  desired absolute jump target.
- in_link  input  1  1 = JAL, 0 = J.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_instr  output  32  encoded instruction; 32'h0 on error.
- out_err  output  2  bit0 = target misaligned; bit1 = region mismatch.
- enc_count  output  CNT_W  results delivered with out_err==0.
- err_count  output  CNT_W  results delivered with out_err!=0.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. Any in-flight requests are discarded.
- Handshakes:
  - Input transfer on in_valid && in_ready. Output transfer on out_valid && out_ready.
  - out_valid, out_instr and out_err are held stable while out_valid && !out_ready.
- Pipeline:
  - Stage 1 registers pc, target and link. Stage 2 is the output register.
  - out_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && out_adv.
  - in_ready = !s1_valid || out_adv (combinational from out_ready; no combinational path from in_valid to in_ready).
- Latency: accept at edge N gives out_valid at edge N+2 when there is no backpressure. Throughput is 1 per cycle. Results stay in order. Capacity is 2 requests.
- Simultaneous events: input accept and output transfer in the same cycle are legal and lose no data. The stage-1 contents move to stage 2 while the new request loads stage 1.
- Arithmetic (computed from stage-1 contents, registered into stage 2):
  - pc4 = pc + 32'd4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
  - err[0] = (target[1:0] != 0).
  - err[1] = (target[31:28] != pc4[31:28]).
  - If err == 0: instr = {link ? OPC_JAL : OPC_J, target[27:2]}. Otherwise instr = 32'h0.
  - Both error bits may be set at once.
- Counters:
  - Update only on an output transfer: enc_count++ if out_err==0, else err_count++.
  - Each counter saturates at all-ones and does not wrap.
- No state machine beyond the two valid bits.
- Inputs are ignored when not accepted. X on in_* while in_valid=0 must not propagate.

Decomposition:
- Package mips_pkg holds OPC_J/OPC_JAL defaults, ERR_MISALIGN=0, ERR_REGION=1, and the J-type field positions (opcode [31:26], index [25:0]).
- One sub-module, sat_counter (width parameter, inc input, async reset), instantiated twice for the statistics counters.

Test Plan:
- Basic encode: pc=0x00400000, target=0x00400020, link=0, out_ready=1 → after 2 cycles out_instr=0x08100008, out_err=0; enc_count=1.
- JAL plus misalign: same request with link=1 gives 0x0C100008. Then target=0x00400022 gives out_instr=0, out_err=2'b01, err_count=1.
- Region and wrap:
  - pc=0x0FFFFFFC, target=0x0FFFFF00 → out_err=2'b10, because pc4=0x10000000.
  - pc=0xFFFFFFFC, target=0x00000010 → out_instr=0x08000004, out_err=0.
- Backpressure: out_ready=0, stream 3 back-to-back requests → first 2 accepted, in_ready=0 and outputs stable. Raise out_ready → all 3 delivered in order, one per cycle.
- Streaming: 100 random requests with random out_ready → every result matches the reference model, and enc_count + err_count = 100. Force enc_count to all-ones via preload/long run → it stays all-ones.
- Reset mid-operation: assert reset with 2 requests in flight → out_valid=0, in_ready=1 and counters 0 immediately (asynchronously). No stale result appears after release.
